w5300_lut_sequencer: RTL

Walks a W5300 register-access lookup table (e.g. the interrupt-register LUT) entry by entry. Each 27-bit entry {op, addr[9:0], value[15:0]} is converted into one bus transaction on the downstream W5300 parallel-bus driver using a req/ack handshake. Read results are forwarded as a one-cycle valid strobe. The block sits between the combinational register LUTs (upstream) and the bus driver (downstream).

---
 rtl/w5300_pkg.sv | 28 ++
 rtl/w5300_seq_timeout.sv | 29 ++
 rtl/w5300_lut_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/w5300_pkg.sv
// rtl/w5300_pkg.sv - shared W5300 bus constants, LUT entry field positions and sequencer states
package w5300_pkg;

  localparam logic W5300_OP_READ  = 1'b1;
  localparam logic W5300_OP_WRITE = 1'b0;

  localparam int W5300_ADDR_WIDTH  = 10;
  localparam int W5300_DATA_WIDTH  = 16;
  localparam int W5300_ENTRY_WIDTH = 1 + W5300_ADDR_WIDTH + W5300_DATA_WIDTH;

  localparam int W5300_OP_BIT    = 26;
  localparam int W5300_ADDR_MSB  = 25;
  localparam int W5300_ADDR_LSB  = 16;
  localparam int W5300_VALUE_MSB = 15;
  localparam int W5300_VALUE_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_FETCH       = 3'd1,
    ST_ISSUE       = 3'd2,
    ST_WAIT        = 3'd3,
    ST_NEXT        = 3'd4,
    ST_DONE        = 3'd5,
    ST_VERIFY      = 3'd6,
    ST_VERIFY_WAIT = 3'd7
  } seq_state_e;

endpackage

// File: rtl/w5300_seq_timeout.sv
// rtl/w5300_seq_timeout.sv - loadable down-counter flagging an expired bus_ack wait
module w5300_seq_timeout #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // A zero load value never reaches 1, which is how the timeout is disabled.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = enable && (count == WIDTH'(1));

endmodule

// File: rtl/w5300_lut_sequencer.sv
// rtl/w5300_lut_sequencer.sv - walks a W5300 register LUT into req/ack bus transactions (option: W5300_SEQ_READBACK_VERIFY_EN)
module w5300_lut_sequencer
  import w5300_pkg::*;
#(
  parameter int ENTRY_COUNT    = 8,
  parameter int INDEX_WIDTH    = 6,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [INDEX_WIDTH-1:0]           lut_index,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0]   lut_data,
  output logic                             bus_req,
  output logic                             bus_op,
  output logic [ADDR_WIDTH-1:0]            bus_addr,
  output logic [DATA_WIDTH-1:0]            bus_wdata,
  input  logic                             bus_ack,
  input  logic [DATA_WIDTH-1:0]            bus_rdata,
  output logic                             rd_valid,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             err
);

  localparam int OP_BIT = ADDR_WIDTH + DATA_WIDTH;
  localparam int TO_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(ENTRY_COUNT - 1);
  localparam logic [TO_W-1:0]        TO_LOAD    = TO_W'(TIMEOUT_CYCLES);

  if ((ENTRY_COUNT < 1) || (ENTRY_COUNT > (1 << INDEX_WIDTH))) begin : g_bad_entry_count
    $error("ENTRY_COUNT must be within 1..2**INDEX_WIDTH");
  end

  seq_state_e state, state_d;

  logic start_ok, fetch, req_on, ack_hit, abort, idx_inc;
  logic to_enable, to_expired;

  logic                  entry_op;
  logic [ADDR_WIDTH-1:0] entry_addr;
  logic [DATA_WIDTH-1:0] entry_value;

  assign entry_op    = lut_data[OP_BIT];
  assign entry_addr  = lut_data[OP_BIT-1 -: ADDR_WIDTH];
  assign entry_value = lut_data[DATA_WIDTH-1:0];

`ifdef W5300_SEQ_READBACK_VERIFY_EN
  logic [DATA_WIDTH-1:0] verify_value;
  assign to_enable = (state == ST_WAIT) || (state == ST_VERIFY_WAIT);
`else
  assign to_enable = (state == ST_WAIT);
`endif

  w5300_seq_timeout #(
    .WIDTH (TO_W)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .load       (req_on),
    .load_value (TO_LOAD),
    .enable     (to_enable),
    .expired    (to_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    start_ok = 1'b0;
    fetch    = 1'b0;
    req_on   = 1'b0;
    ack_hit  = 1'b0;
    abort    = 1'b0;
    idx_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        fetch   = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        req_on  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // An ack arriving on the expiry cycle still completes the transaction.
        if (bus_ack) begin
          ack_hit = 1'b1;
          state_d = ST_NEXT;
`ifdef W5300_SEQ_READBACK_VERIFY_EN
          if (bus_op == W5300_OP_WRITE) begin
            state_d = ST_VERIFY;
          end
`endif
        end else if (to_expired) begin
          abort   = 1'b1;
          state_d = ST_DONE;
        end
      end
`ifdef W5300_SEQ_READBACK_VERIFY_EN
      ST_VERIFY: begin
        req_on  = 1'b1;
        state_d = ST_VERIFY_WAIT;
      end
      ST_VERIFY_WAIT: begin
        if (bus_ack) begin
          ack_hit = 1'b1;
          state_d = ST_NEXT;
        end else if (to_expired) begin
          abort   = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif
      ST_NEXT: begin
        if (lut_index == LAST_INDEX) begin
          state_d = ST_DONE;
        end else begin
          idx_inc = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_index <= '0;
      bus_req   <= 1'b0;
      bus_op    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
      err       <= 1'b0;
`ifdef W5300_SEQ_READBACK_VERIFY_EN
      verify_value <= '0;
`endif
    end else begin
      rd_valid <= 1'b0;
      if (start_ok) begin
        lut_index <= '0;
        err       <= 1'b0;
      end
      if (idx_inc) begin
        lut_index <= lut_index + 1'b1;
      end
      if (fetch) begin
        bus_op    <= entry_op;
        bus_addr  <= entry_addr;
        bus_wdata <= (entry_op == W5300_OP_READ) ? '0 : entry_value;
      end
      if (req_on) begin
        bus_req <= 1'b1;
      end
      if (ack_hit || abort) begin
        bus_req <= 1'b0;
      end
      if (abort) begin
        err <= 1'b1;
      end
      if (ack_hit && (state == ST_WAIT) && (bus_op == W5300_OP_READ)) begin
        rd_valid <= 1'b1;
        rd_addr  <= bus_addr;
        rd_data  <= bus_rdata;
      end
`ifdef W5300_SEQ_READBACK_VERIFY_EN
      // Readback reuses the bus field registers as a read of the same address.
      if (ack_hit && (state == ST_WAIT) && (bus_op == W5300_OP_WRITE)) begin
        verify_value <= bus_wdata;
        bus_op       <= W5300_OP_READ;
        bus_wdata    <= '0;
      end
      if (ack_hit && (state == ST_VERIFY_WAIT) && (bus_rdata != verify_value)) begin
        err <= 1'b1;
      end
`endif
    end
  end

  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);

endmodule
